video_memory_streamer: RTL and testbench

// Parametrised successor to the video SRAM front end. Maps BANK_COUNT dual-port SRAM macros
// (rw port 0, r port 1) onto the peripheral bus at a configurable base and serves the video

---
 rtl/video_memory_streamer.sv | 190 +++++++++++++++++++
 tb/tb_video_memory_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_memory_streamer.sv
// Banked dual-port SRAM front end: peripheral bus on port 0,
// video burst prefetcher with a small pop-handshake FIFO on port 1.
module video_memory_streamer #(
  parameter int SRAM_ADDRESS_SIZE = 9,
  parameter int BANK_COUNT_LOG2 = 2,
  parameter int BASE_ADDRESS = 0,
  parameter int FIFO_DEPTH_LOG2 = 3,
  localparam int BANK_COUNT = 1 << BANK_COUNT_LOG2,
  localparam int AW = SRAM_ADDRESS_SIZE + BANK_COUNT_LOG2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          peripheralBus_we,
  input  logic                          peripheralBus_oe,
  output logic                          peripheralBus_busy,
  input  logic [23:0]                   peripheralBus_address,
  input  logic [3:0]                    peripheralBus_byteSelect,
  input  logic [31:0]                   peripheralBus_dataWrite,
  output logic [31:0]                   peripheralBus_dataRead,
  output logic                          requestOutput,
  input  logic                          video_start,
  input  logic [AW-1:0]                 video_startAddress,
  input  logic [AW:0]                   video_wordCount,
  input  logic                          video_pop,
  output logic [31:0]                   video_data,
  output logic                          video_dataValid,
  output logic                          video_busy,
  output logic [BANK_COUNT-1:0]         sram_csb0,
  output logic [BANK_COUNT-1:0]         sram_csb1,
  output logic                          sram_web0,
  output logic [3:0]                    sram_wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0]  sram_addr0,
  output logic [SRAM_ADDRESS_SIZE-1:0]  sram_addr1,
  output logic [31:0]                   sram_din0,
  input  logic [32*BANK_COUNT-1:0]      sram_dout0,
  input  logic [32*BANK_COUNT-1:0]      sram_dout1
);

  localparam int BW = 24 - AW - 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam int SA = SRAM_ADDRESS_SIZE;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic                       valid;
  logic [BANK_COUNT_LOG2-1:0] bus_bank;
  logic                       bus_access;
  logic                       rd_req;
  logic                       read_ready;
  logic [BANK_COUNT_LOG2-1:0] rd_bank;
  logic [31:0]                rd_word;
  logic [31:0]                rd_mask;
  logic                       unused;

  assign unused = ^peripheralBus_address[1:0];

  assign valid =
    peripheralBus_address[23:AW+2] == BW'(BASE_ADDRESS);
  assign bus_bank = peripheralBus_address[AW+1:SA+2];
  assign bus_access = (peripheralBus_we | peripheralBus_oe)
    & valid & !rst;
  assign rd_req = peripheralBus_oe & valid & !rst;

  assign sram_csb0 = bus_access
    ? ~(BANK_COUNT'(1) << bus_bank) : '1;
  assign sram_web0 = !(peripheralBus_we & valid & !rst);
  assign sram_wmask0 = peripheralBus_byteSelect;
  assign sram_addr0 = peripheralBus_address[SA+1:2];
  assign sram_din0 = peripheralBus_dataWrite;

  assign requestOutput = rd_req;
  assign peripheralBus_busy = rd_req & !read_ready;

  assign rd_word = sram_dout0[rd_bank*32 +: 32];
  assign rd_mask = {{8{peripheralBus_byteSelect[3]}},
                    {8{peripheralBus_byteSelect[2]}},
                    {8{peripheralBus_byteSelect[1]}},
                    {8{peripheralBus_byteSelect[0]}}};
  assign peripheralBus_dataRead = (rd_req & read_ready)
    ? (rd_word & rd_mask) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      read_ready <= 1'b0;
      rd_bank <= '0;
    end else begin
      read_ready <= rd_req;
      rd_bank <= bus_bank;
    end
  end

  logic [0:0]                 state;
  logic [AW-1:0]              ptr;
  logic [AW:0]                remaining;
  logic                       in_flight;
  logic [BANK_COUNT_LOG2-1:0] fl_bank;
  logic [31:0]                fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_next;
  logic [CW-1:0]              count;
  logic [CW-1:0]              occ;
  logic                       issue;
  logic                       push;
  logic                       pop;
  logic [31:0]                push_data;
  logic [31:0]                head_next;

  // In-flight words reserve a FIFO slot so a landing word always fits.
  assign occ = count + CW'(in_flight);
  assign issue = !rst && state == S_STREAM
    && remaining != '0 && occ < CW'(DEPTH);

  assign sram_csb1 = issue
    ? ~(BANK_COUNT'(1) << ptr[AW-1:SA]) : '1;
  assign sram_addr1 = ptr[SA-1:0];

  assign push = in_flight;
  assign push_data = sram_dout1[fl_bank*32 +: 32];
  assign pop = video_pop && count != '0;
  assign rd_next = rd_ptr + FIFO_DEPTH_LOG2'(1);

  assign video_dataValid = count != '0;
  assign video_busy = state == S_STREAM;

  always_comb begin
    head_next = video_data;
    if (pop) begin
      if (count > CW'(1)) head_next = fifo_mem[rd_next];
      else if (push) head_next = push_data;
    end else if (count == '0 && push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      fl_bank <= '0;
    end else begin
      in_flight <= issue;
      fl_bank <= ptr[AW-1:SA];
      unique case (state)
        S_IDLE: begin
          if (video_start && video_wordCount != '0) begin
            ptr <= video_startAddress;
            remaining <= video_wordCount;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (issue) begin
            ptr <= ptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
          end
          if (remaining == '0 && !in_flight) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      video_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_next;
      unique case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: count <= count;
      endcase
      video_data <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_video_memory_streamer.sv
// Directed bench for video_memory_streamer with a
// behavioural 4-bank dual-port SRAM model.
module tb_video_memory_streamer;

  logic         clk;
  logic         rst;
  logic         we;
  logic         oe;
  logic         busy;
  logic [23:0]  address;
  logic [3:0]   bs;
  logic [31:0]  dw;
  logic [31:0]  dr;
  logic         req;
  logic         v_start;
  logic [10:0]  v_addr;
  logic [11:0]  v_count;
  logic         v_pop;
  logic [31:0]  v_data;
  logic         v_valid;
  logic         v_busy;
  logic [3:0]   csb0;
  logic [3:0]   csb1;
  logic         web0;
  logic [3:0]   wmask0;
  logic [8:0]   addr0;
  logic [8:0]   addr1;
  logic [31:0]  din0;
  logic [127:0] dout0;
  logic [127:0] dout1;

  int total;
  int passed;
  int failed;
  int issues;
  logic [8:0] last_addr;
  logic [3:0] last_csb;

  video_memory_streamer dut (
    .clk(clk),
    .rst(rst),
    .peripheralBus_we(we),
    .peripheralBus_oe(oe),
    .peripheralBus_busy(busy),
    .peripheralBus_address(address),
    .peripheralBus_byteSelect(bs),
    .peripheralBus_dataWrite(dw),
    .peripheralBus_dataRead(dr),
    .requestOutput(req),
    .video_start(v_start),
    .video_startAddress(v_addr),
    .video_wordCount(v_count),
    .video_pop(v_pop),
    .video_data(v_data),
    .video_dataValid(v_valid),
    .video_busy(v_busy),
    .sram_csb0(csb0),
    .sram_csb1(csb1),
    .sram_web0(web0),
    .sram_wmask0(wmask0),
    .sram_addr0(addr0),
    .sram_addr1(addr1),
    .sram_din0(din0),
    .sram_dout0(dout0),
    .sram_dout1(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stored as delta against a fixed pattern so the model needs no preload.
  bit [31:0] mem [4][512];

  function automatic logic [31:0] pat(input int b, input int a);
    return 32'hC000_0000 | (b << 16) | a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++)
      if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!csb1[b])
        dout1[b*32 +: 32] <= mem[b][addr1] ^ pat(b, int'(addr1));
      if (!csb0[b]) begin
        if (!web0)
          mem[b][addr0] <= merge(mem[b][addr0] ^ pat(b, int'(addr0)),
                                 din0, wmask0) ^ pat(b, int'(addr0));
        else
          dout0[b*32 +: 32] <= mem[b][addr0] ^ pat(b, int'(addr0));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    passed = 0;
    failed = 0;
    rst = 1'b1;
    we = 1'b0;
    oe = 1'b0;
    address = '0;
    bs = '0;
    dw = '0;
    v_start = 1'b0;
    v_addr = '0;
    v_count = '0;
    v_pop = 1'b0;

    nxt; nxt; #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", req, 0);
    chk("rst_dr", dr, 0);
    chk("rst_valid", v_valid, 0);
    chk("rst_vbusy", v_busy, 0);
    chk("rst_csb0", csb0, 4'hF);
    chk("rst_csb1", csb1, 4'hF);
    chk("rst_web0", web0, 1);
    chk("rst_vdata", v_data, 0);
    nxt; rst = 1'b0;

    // Bus write bank 2 word 2, then masked read back
    nxt;
    we = 1'b1; address = 24'h001008; dw = 32'hA5A5_1234; bs = 4'hF;
    #1;
    chk("wr_csb0", csb0, 4'b1011);
    chk("wr_web0", web0, 0);
    chk("wr_addr0", addr0, 9'h002);
    chk("wr_busy", busy, 0);
    nxt;
    we = 1'b0; oe = 1'b1; bs = 4'b0110;
    #1;
    chk("rd_busy_n", busy, 1);
    chk("rd_csb0", csb0, 4'b1011);
    chk("rd_req", req, 1);
    chk("rd_dr_n", dr, 0);
    nxt; #1;
    chk("rd_busy_n1", busy, 0);
    chk("rd_data", dr, 32'h00A5_1200);
    nxt; oe = 1'b0; #1;
    chk("rd_drop_dr", dr, 0);

    // Out-of-window address
    nxt;
    we = 1'b1; address = 24'h010000; bs = 4'hF; dw = 32'hDEAD_BEEF;
    #1;
    chk("inv_wr_csb0", csb0, 4'hF);
    chk("inv_wr_web0", web0, 1);
    nxt; we = 1'b0; oe = 1'b1; #1;
    chk("inv_busy", busy, 0);
    chk("inv_req", req, 0);
    chk("inv_csb0", csb0, 4'hF);
    nxt; #1;
    chk("inv_dr", dr, 0);
    nxt; oe = 1'b0;

    // Wrapping burst of 3 with pop held high
    nxt;
    v_start = 1'b1; v_addr = 11'h7FF; v_count = 12'd3; v_pop = 1'b1;
    #1;
    chk("b3_idle_csb1", csb1, 4'hF);
    nxt; v_start = 1'b0; #1;
    chk("b3_c0_csb1", csb1, 4'b0111);
    chk("b3_c0_addr1", addr1, 9'h1FF);
    chk("b3_c0_vbusy", v_busy, 1);
    nxt; #1;
    chk("b3_c1_csb1", csb1, 4'b1110);
    chk("b3_c1_addr1", addr1, 9'h000);
    chk("b3_c1_valid", v_valid, 0);
    nxt; #1;
    chk("b3_c2_csb1", csb1, 4'b1110);
    chk("b3_c2_addr1", addr1, 9'h001);
    chk("b3_w0_valid", v_valid, 1);
    chk("b3_w0", v_data, 32'hC003_01FF);
    nxt; #1;
    chk("b3_c3_csb1", csb1, 4'hF);
    chk("b3_w1", v_data, 32'hC000_0000);
    nxt; #1;
    chk("b3_w2", v_data, 32'hC000_0001);
    chk("b3_c4_vbusy", v_busy, 1);
    nxt; #1;
    chk("b3_end_valid", v_valid, 0);
    chk("b3_end_vbusy", v_busy, 0);
    v_pop = 1'b0;

    // Burst of 20 without pops fills the FIFO
    nxt;
    v_start = 1'b1; v_addr = 11'h010; v_count = 12'd20;
    nxt; v_start = 1'b0;
    issues = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (csb1 != 4'hF) issues++;
      nxt;
    end
    #1;
    chk("b20_issues", issues, 8);
    chk("b20_csb1", csb1, 4'hF);
    chk("b20_valid", v_valid, 1);
    chk("b20_head", v_data, 32'hC000_0010);
    chk("b20_vbusy", v_busy, 1);

    // Start during STREAM is ignored
    v_start = 1'b1; v_addr = 11'h200; v_count = 12'd5;
    nxt; v_start = 1'b0; #1;
    chk("b20_restart_csb1", csb1, 4'hF);

    // One pop frees one slot
    v_pop = 1'b1;
    nxt; v_pop = 1'b0;
    issues = 0;
    last_addr = '0;
    last_csb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (csb1 != 4'hF) begin
        issues++;
        last_addr = addr1;
        last_csb = csb1;
      end
      nxt;
    end
    #1;
    chk("pop_issues", issues, 1);
    chk("pop_addr1", last_addr, 9'h018);
    chk("pop_csb1", last_csb, 4'b1110);
    chk("pop_head", v_data, 32'hC000_0011);

    rst = 1'b1;
    nxt; rst = 1'b0; #1;
    chk("abort_vbusy", v_busy, 0);
    chk("abort_valid", v_valid, 0);

    // Zero-length start
    nxt;
    v_start = 1'b1; v_addr = 11'h005; v_count = 12'd0;
    nxt; v_start = 1'b0;
    issues = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (csb1 != 4'hF) issues++;
      nxt;
    end
    #1;
    chk("zero_issues", issues, 0);
    chk("zero_vbusy", v_busy, 0);

    // Reset with 4 queued and 1 in flight
    nxt;
    v_start = 1'b1; v_addr = 11'h020; v_count = 12'd5;
    nxt; v_start = 1'b0;
    repeat (5) nxt;
    #1;
    chk("q4_valid", v_valid, 1);
    chk("q4_vbusy", v_busy, 1);
    chk("q4_head", v_data, 32'hC000_0020);
    rst = 1'b1; #1;
    chk("q4_rst_csb1", csb1, 4'hF);
    nxt; #1;
    chk("q4_post_valid", v_valid, 0);
    chk("q4_post_vbusy", v_busy, 0);
    chk("q4_post_vdata", v_data, 0);
    rst = 1'b0;
    repeat (3) nxt;
    #1;
    chk("q4_drop_valid", v_valid, 0);

    // Reset on a cycle that would otherwise issue
    nxt;
    v_start = 1'b1; v_addr = 11'h040; v_count = 12'd5;
    nxt; v_start = 1'b0; #1;
    chk("mid_issue_csb1", csb1, 4'b1110);
    rst = 1'b1; #1;
    chk("mid_rst_csb1", csb1, 4'hF);
    nxt; rst = 1'b0; #1;
    chk("mid_rst_vbusy", v_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
